// File: rtl/arbiter_rr_if.sv
// Request/response bundle for arbiter_rr: per-channel request side plus the
// single registered output beat and the packet-lock indicator.
interface arbiter_rr_if #(
    parameter int unsigned SOURCES = 4,
    parameter int unsigned DATA_W  = 8
);
    localparam int unsigned SRC_W = (SOURCES > 1) ? $clog2(SOURCES) : 1;

    logic [SOURCES-1:0]             req_valid;
    logic [SOURCES-1:0][DATA_W-1:0] req_data;
    logic [SOURCES-1:0]             req_last;
    logic [SOURCES-1:0]             req_ready;
    logic                           out_valid;
    logic [DATA_W-1:0]              out_data;
    logic [SRC_W-1:0]               out_src;
    logic                           out_last;
    logic                           out_ready;
    logic                           locked;

    modport master (
        output req_valid, req_data, req_last, out_ready,
        input  req_ready, out_valid, out_data, out_src, out_last, locked
    );

    modport slave (
        input  req_valid, req_data, req_last, out_ready,
        output req_ready, out_valid, out_data, out_src, out_last, locked
    );
endinterface

// File: rtl/arbiter_rr.sv
// Packet-aware N:1 arbiter (fixed priority or round-robin) with a single
// registered output stage; a multi-beat packet keeps the grant until its last beat.
module arbiter_rr #(
    parameter int unsigned SOURCES = 4,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned MODE    = 1
) (
    input  logic         clk,
    input  logic         n_rst,
    arbiter_rr_if.slave  bus
);
    localparam int unsigned SRC_W = (SOURCES > 1) ? $clog2(SOURCES) : 1;

    typedef enum logic {
        ST_OPEN,
        ST_LOCKED
    } lock_state_e;

    lock_state_e        state_q, state_d;
    logic [SRC_W-1:0]   lock_src_q, lock_src_d;
    logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               out_valid_q, out_valid_d;
    logic [DATA_W-1:0]  out_data_q, out_data_d;
    logic [SRC_W-1:0]   out_src_q, out_src_d;
    logic               out_last_q, out_last_d;

    logic               slot_free;
    logic               grant_vld;
    logic [SRC_W-1:0]   grant_idx;
    int unsigned        rr_idx;
    logic [SOURCES-1:0] ready_vec;
    logic               xfer;
    logic               xfer_last;

    assign slot_free = !out_valid_q || bus.out_ready;

    // Grant selection; while locked only the lock owner may be chosen.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        rr_idx    = 0;
        if (state_q == ST_LOCKED) begin
            grant_idx = lock_src_q;
            grant_vld = bus.req_valid[lock_src_q];
        end else if (MODE == 0) begin
            for (int unsigned i = 0; i < SOURCES; i++) begin
                if (!grant_vld && bus.req_valid[i]) begin
                    grant_vld = 1'b1;
                    grant_idx = SRC_W'(i);
                end
            end
        end else begin
            for (int unsigned k = 0; k < SOURCES; k++) begin
                rr_idx = int'(rr_ptr_q) + k;
                if (rr_idx >= SOURCES) begin
                    rr_idx = rr_idx - SOURCES;
                end
                if (!grant_vld && bus.req_valid[rr_idx]) begin
                    grant_vld = 1'b1;
                    grant_idx = SRC_W'(rr_idx);
                end
            end
        end
    end

    always_comb begin
        ready_vec = '0;
        for (int unsigned i = 0; i < SOURCES; i++) begin
            ready_vec[i] = n_rst && slot_free && grant_vld && (grant_idx == SRC_W'(i));
        end
    end

    assign bus.req_ready = ready_vec;
    assign xfer          = |ready_vec;
    assign xfer_last     = bus.req_last[grant_idx];

    // Lock FSM: a non-last transfer opens a packet, a last transfer closes it.
    always_comb begin
        state_d    = state_q;
        lock_src_d = lock_src_q;
        if (xfer) begin
            lock_src_d = grant_idx;
            state_d    = xfer_last ? ST_OPEN : ST_LOCKED;
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (MODE == 0) begin
            rr_ptr_d = '0;
        end else if (xfer && xfer_last) begin
            rr_ptr_d = (grant_idx == SRC_W'(SOURCES - 1)) ? '0 : grant_idx + SRC_W'(1);
        end
    end

    // Output stage: load on transfer, drop valid on a free slot, else hold.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        out_last_d  = out_last_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = bus.req_data[grant_idx];
            out_src_d   = grant_idx;
            out_last_d  = xfer_last;
        end else if (slot_free) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= ST_OPEN;
            lock_src_q  <= '0;
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            lock_src_q  <= lock_src_d;
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            out_last_q  <= out_last_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;
    assign bus.out_last  = out_last_q;
    assign bus.locked    = (state_q == ST_LOCKED);
endmodule

// File: tb/tb_arbiter_rr.sv
// Drives a round-robin and a fixed-priority arbiter_rr with identical stimulus;
// expected beats are queued by a packet-level model and popped by a monitor.
module tb_arbiter_rr;
    logic clk;
    logic n_rst;
    int   tests;
    int   fails;

    typedef struct {
        logic [7:0] data;
        int         src;
        logic       last;
    } beat_t;

    beat_t q0[$];
    beat_t q1[$];

    // model state, index 0 = fixed priority DUT, 1 = round-robin DUT
    int   m_ov[2];
    int   m_lock[2];
    int   m_ptr[2];

    arbiter_rr_if #(.SOURCES(4), .DATA_W(8)) b0 ();
    arbiter_rr_if #(.SOURCES(4), .DATA_W(8)) b1 ();

    arbiter_rr #(.SOURCES(4), .DATA_W(8), .MODE(0)) u_fixed (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (b0.slave)
    );

    arbiter_rr #(.SOURCES(4), .DATA_W(8), .MODE(1)) u_rr (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (b1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input int mode, input int lock, input int ptr, input logic [3:0] v);
        if (lock >= 0) return v[lock] ? lock : -1;
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (mode == 1) ? (ptr + k) % 4 : k;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        for (int n = 0; n < 2; n++) begin
            m_ov[n]   = 0;
            m_lock[n] = -1;
            m_ptr[n]  = 0;
        end
        q0.delete();
        q1.delete();
    endfunction

    // One cycle: drive inputs, check registered and combinational outputs,
    // then advance the model across the coming edge.
    task automatic step(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d, input logic ordy);
        @(posedge clk);
        #2;
        b0.req_valid = v; b0.req_last = l; b0.req_data = d; b0.out_ready = ordy;
        b1.req_valid = v; b1.req_last = l; b1.req_data = d; b1.out_ready = ordy;
        #1;
        for (int n = 0; n < 2; n++) begin
            logic [3:0] act_rdy;
            logic       act_ov;
            logic       act_lk;
            int         g;
            logic [3:0] exp_rdy;
            beat_t      b;
            act_rdy = (n == 1) ? b1.req_ready : b0.req_ready;
            act_ov  = (n == 1) ? b1.out_valid : b0.out_valid;
            act_lk  = (n == 1) ? b1.locked    : b0.locked;
            chk($sformatf("m%0d_out_valid", n), 32'(act_ov), 32'(m_ov[n]));
            chk($sformatf("m%0d_locked", n), 32'(act_lk), 32'(m_lock[n] >= 0));
            g = (m_ov[n] == 0 || ordy) ? pick(n, m_lock[n], m_ptr[n], v) : -1;
            exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0000;
            chk($sformatf("m%0d_req_ready", n), 32'(act_rdy), 32'(exp_rdy));
            if (g >= 0) begin
                b.data = d[g*8 +: 8];
                b.src  = g;
                b.last = l[g];
                if (n == 1) q1.push_back(b); else q0.push_back(b);
                m_ov[n]   = 1;
                m_lock[n] = l[g] ? -1 : g;
                if (n == 1 && l[g]) m_ptr[n] = (g + 1) % 4;
            end else if (m_ov[n] == 0 || ordy) begin
                m_ov[n] = 0;
            end
        end
    endtask

    task automatic pulse_reset(input int cycles);
        @(posedge clk);
        #2;
        n_rst = 1'b0;
        #1;
        chk("rst_out_valid_rr", 32'(b1.out_valid), 32'd0);
        chk("rst_locked_rr", 32'(b1.locked), 32'd0);
        chk("rst_out_data_rr", 32'(b1.out_data), 32'd0);
        chk("rst_out_src_rr", 32'(b1.out_src), 32'd0);
        chk("rst_req_ready_rr", 32'(b1.req_ready), 32'd0);
        chk("rst_out_valid_fx", 32'(b0.out_valid), 32'd0);
        chk("rst_locked_fx", 32'(b0.locked), 32'd0);
        chk("rst_req_ready_fx", 32'(b0.req_ready), 32'd0);
        model_reset();
        repeat (cycles) @(posedge clk);
        #2;
        b0.req_valid = '0; b1.req_valid = '0;
        b0.out_ready = 1'b1; b1.out_ready = 1'b1;
        n_rst = 1'b1;
    endtask

    task automatic mon_beat(input int n, input logic [7:0] data, input logic [1:0] src, input logic last);
        beat_t e;
        if ((n == 1 && q1.size() == 0) || (n == 0 && q0.size() == 0)) begin
            tests++;
            fails++;
            $display("FAIL m%0d_unexpected_beat: got src %0d data %0h expected no beat", n, src, data);
        end else begin
            e = (n == 1) ? q1.pop_front() : q0.pop_front();
            chk($sformatf("m%0d_out_data", n), 32'(data), 32'(e.data));
            chk($sformatf("m%0d_out_src", n), 32'(src), 32'(e.src));
            chk($sformatf("m%0d_out_last", n), 32'(last), 32'(e.last));
        end
    endtask

    always @(negedge clk) begin
        if (n_rst && b1.out_valid && b1.out_ready) mon_beat(1, b1.out_data, b1.out_src, b1.out_last);
        if (n_rst && b0.out_valid && b0.out_ready) mon_beat(0, b0.out_data, b0.out_src, b0.out_last);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tests = 0;
        fails = 0;
        n_rst = 1'b0;
        b0.req_valid = '0; b0.req_last = '0; b0.req_data = '0; b0.out_ready = 1'b0;
        b1.req_valid = '0; b1.req_last = '0; b1.req_data = '0; b1.out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        pulse_reset(2);

        // all channels requesting single-beat packets: rotation vs fixed
        repeat (6) step(4'b1111, 4'b1111, 32'h13121110, 1'b1);
        repeat (4) step(4'b1110, 4'b1111, 32'h23222120, 1'b1);

        // ch2 three-beat packet with ch0 also pending
        step(4'b0100, 4'b0000, 32'h00A00000, 1'b1);
        step(4'b0101, 4'b0000, 32'h00A100F0, 1'b1);
        step(4'b0101, 4'b0100, 32'h00A200F1, 1'b1);
        step(4'b0001, 4'b0001, 32'h000000F2, 1'b1);
        step(4'b0000, 4'b0000, 32'h0, 1'b1);

        // backpressure hold then back-to-back reload
        step(4'b0001, 4'b0001, 32'h00000055, 1'b1);
        repeat (3) step(4'b0110, 4'b0110, 32'h00666600, 1'b0);
        step(4'b0110, 4'b0110, 32'h00777700, 1'b1);
        step(4'b0000, 4'b0000, 32'h0, 1'b1);

        // locked ch1 drops valid while ch0 waits
        step(4'b0010, 4'b0000, 32'h00003100, 1'b1);
        repeat (2) step(4'b0001, 4'b0001, 32'h000000C0, 1'b1);
        step(4'b0011, 4'b0010, 32'h000032C0, 1'b1);
        step(4'b0001, 4'b0001, 32'h000000C1, 1'b1);

        // reset in the middle of a ch1 packet, then ch3 alone
        step(4'b0010, 4'b0000, 32'h00004100, 1'b1);
        step(4'b0010, 4'b0000, 32'h00004200, 1'b0);
        pulse_reset(1);
        step(4'b1000, 4'b1000, 32'hD3000000, 1'b1);
        step(4'b0000, 4'b0000, 32'h0, 1'b1);

        // random traffic with occasional resets
        for (int c = 0; c < 600; c++) begin
            logic [3:0] v;
            logic [3:0] l;
            v = 4'($urandom);
            l = 4'($urandom) | 4'($urandom);
            step(v, l, $urandom, ($urandom_range(0, 3) != 0));
            if (c % 200 == 199) pulse_reset(1);
        end

        repeat (4) step(4'b0000, 4'b0000, 32'h0, 1'b1);
        @(posedge clk);
        #3;
        chk("drain_q_rr", 32'(q1.size()), 32'd0);
        chk("drain_q_fx", 32'(q0.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
